// File: rtl/count_step_mod_if.sv
// count_step_mod_if: control/status bundle for count_step_mod.
//   master drives en, load, load_val, step, dir, mode
//   slave  drives count, tc, done
interface count_step_mod_if #(
  parameter int WIDTH  = 4,
  parameter int STEP_W = 2
) ();
  logic              en;
  logic              load;
  logic [WIDTH-1:0]  load_val;
  logic [STEP_W-1:0] step;
  logic              dir;
  logic [1:0]        mode;
  logic [WIDTH-1:0]  count;
  logic              tc;
  logic              done;

  modport master (
    output en, load, load_val, step, dir, mode,
    input  count, tc, done
  );

  modport slave (
    input  en, load, load_val, step, dir, mode,
    output count, tc, done
  );
endinterface

// File: rtl/count_step_mod.sv
// count_step_mod: up/down step counter with programmable modulus and
// wrap / saturate / one-shot limit modes, parallel load and a registered
// terminal-event pulse.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : count_step_mod_if.slave
//          in : en, load, load_val, step, dir (0 up / 1 down), mode
//          out: count, tc (one-cycle event pulse), done (one-shot halted)
//
// state | meaning
// ------+-----------------------------------------------
// RUN   | normal counting
// HALT  | one-shot reached its limit; count frozen, done=1
module count_step_mod #(
  parameter int WIDTH   = 4,
  parameter int STEP_W  = 2,
  parameter int MODULUS = 16
) (
  input  logic clk,
  input  logic rst,
  count_step_mod_if.slave bus
);

  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_chk_mod
    $error("count_step_mod: MODULUS must be in 2..2**WIDTH");
  end
  if ((1 << STEP_W) - 1 >= MODULUS) begin : g_chk_step
    $error("count_step_mod: largest step must be below MODULUS");
  end

  localparam int W1 = WIDTH + 1;
  localparam logic [W1-1:0] MOD_X = W1'(MODULUS);
  localparam logic [W1-1:0] MAX_X = W1'(MODULUS - 1);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  localparam logic [1:0] MODE_SAT = 2'b01;
  localparam logic [1:0] MODE_ONE = 2'b10;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             done_q, done_d;

  logic [W1-1:0] cnt_x;
  logic [W1-1:0] step_x;
  logic [W1-1:0] sum_up;
  logic [W1-1:0] wrap_dn;
  logic [W1-1:0] diff_dn;
  logic [W1-1:0] load_x;
  logic          cross_up;
  logic          cross_dn;
  logic          reach_up;
  logic          reach_dn;

  always_comb begin
    cnt_x   = {1'b0, count_q};
    step_x  = W1'(bus.step);
    load_x  = {1'b0, bus.load_val};
    sum_up  = cnt_x + step_x;
    // Stays non-negative: only used when step > count, result < MODULUS.
    wrap_dn = cnt_x + MOD_X - step_x;
    diff_dn = cnt_x - step_x;
    cross_up = (sum_up >= MOD_X);
    cross_dn = (step_x > cnt_x);
    // One-shot treats landing exactly on the limit as terminal.
    reach_up = (sum_up >= MAX_X);
    reach_dn = (step_x >= cnt_x);
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tc_d    = 1'b0;
    done_d  = done_q;

    if (bus.load) begin
      count_d = (load_x > MAX_X) ? MAX_X[WIDTH-1:0] : bus.load_val;
      done_d  = 1'b0;
      state_d = RUN;
    end else if (state_q == RUN && bus.en && bus.step != '0) begin
      unique case (bus.mode)
        MODE_SAT: begin
          if (!bus.dir) begin
            count_d = cross_up ? MAX_X[WIDTH-1:0] : sum_up[WIDTH-1:0];
            tc_d    = cross_up;
          end else begin
            count_d = cross_dn ? '0 : diff_dn[WIDTH-1:0];
            tc_d    = cross_dn;
          end
        end
        MODE_ONE: begin
          if (!bus.dir) begin
            count_d = reach_up ? MAX_X[WIDTH-1:0] : sum_up[WIDTH-1:0];
            tc_d    = reach_up;
          end else begin
            count_d = reach_dn ? '0 : diff_dn[WIDTH-1:0];
            tc_d    = reach_dn;
          end
          if (tc_d) begin
            done_d  = 1'b1;
            state_d = HALT;
          end
        end
        default: begin
          // Wrap; the reserved encoding also lands here.
          if (!bus.dir) begin
            count_d = cross_up ? sum_up[WIDTH-1:0] - MOD_X[WIDTH-1:0]
                               : sum_up[WIDTH-1:0];
            tc_d    = cross_up;
          end else begin
            count_d = cross_dn ? wrap_dn[WIDTH-1:0] : diff_dn[WIDTH-1:0];
            tc_d    = cross_dn;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      count_q <= '0;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
    end
  end

  assign bus.count = count_q;
  assign bus.tc    = tc_q;
  assign bus.done  = done_q;

endmodule
